clock_recovery_ctrl: RTL and testbench

Lock-acquisition and supervision controller for the M-sequence clock-recovery datapath.
- Consumes the datapath's per-frame run-length measurements and its edge pulses.
- Decides when the measurement is stable and loads the recovered-clock divider period.
- Freezes that period in holdover when the input degrades, and falls back to the default period after a long outage.
- Sits between the edge detector/frame measurer and the clock_out divider, all on sys_clk.

---
 rtl/clock_recovery_pkg.sv | 19 +
 rtl/cr_tol_cmp.sv | 26 ++
 rtl/clock_recovery_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_clock_recovery_ctrl.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/clock_recovery_pkg.sv
// Shared types and constants for the clock-recovery lock controller.
package clock_recovery_pkg;

  localparam int CR_W       = 24;
  localparam int CR_DEF_CFG = 7982;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ACQUIRE  = 2'd1,
    ST_LOCKED   = 2'd2,
    ST_HOLDOVER = 2'd3
  } cr_state_t;

  // Counter width able to hold values 0..n-1 (never below one bit).
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/cr_tol_cmp.sv
// Tolerance comparator: |a-b| <= TOL, with a measurement of zero rejected.
module cr_tol_cmp
  import clock_recovery_pkg::*;
#(
  parameter int W   = CR_W,
  parameter int TOL = 64
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         nonzero,
  output logic         match
);

  localparam logic [W:0] TOL_V = (W+1)'(TOL);

  logic [W:0] diff;

  // Absolute difference at W+1 bits so the subtraction can never wrap.
  always_comb begin
    if (a >= b) diff = {1'b0, a} - {1'b0, b};
    else        diff = {1'b0, b} - {1'b0, a};
    nonzero = |a;
    match   = nonzero && (diff <= TOL_V);
  end

endmodule

// File: rtl/clock_recovery_ctrl.sv
// Lock acquisition / supervision for the recovered-clock divider period.
module clock_recovery_ctrl
  import clock_recovery_pkg::*;
#(
  parameter int W            = CR_W,
  parameter int DEF_CFG      = CR_DEF_CFG,
  parameter int TOL          = 64,
  parameter int LOCK_CNT     = 3,
  parameter int MISS_MAX     = 2,
  parameter int EDGE_TIMEOUT = 65536,
  parameter int HOLD_MAX     = 2000000
) (
  input  logic         sys_clk,
  input  logic         rst,
  input  logic         en,
  input  logic         edge_pulse,
  input  logic         meas_valid,
  input  logic [W-1:0] meas_val,
  output logic [W-1:0] div_cfg,
  output logic         div_load,
  output logic         locked,
  output logic [1:0]   state,
  output logic         lock_loss
);

  localparam int NUM_CMP = 2;
  localparam int MC_W    = cnt_w(LOCK_CNT + 1);
  localparam int MS_W    = cnt_w(MISS_MAX + 1);
  localparam int EC_W    = cnt_w(EDGE_TIMEOUT + 1);
  localparam int HC_W    = cnt_w(HOLD_MAX);

  localparam logic [W-1:0]    DEF_V     = W'(DEF_CFG);
  localparam logic [MC_W-1:0] LOCK_LAST = MC_W'(LOCK_CNT - 1);
  localparam logic [MS_W-1:0] MISS_LAST = MS_W'(MISS_MAX - 1);
  localparam logic [EC_W-1:0] EDGE_LAST = EC_W'(EDGE_TIMEOUT - 1);
  localparam logic [EC_W-1:0] EDGE_TOP  = EC_W'(EDGE_TIMEOUT);
  localparam logic [HC_W-1:0] HOLD_LAST = HC_W'(HOLD_MAX - 1);

  cr_state_t       st_q, st_d;
  logic [W-1:0]    meas_ref, ref_d;
  logic [MC_W-1:0] match_cnt, mc_d;
  logic [MS_W-1:0] miss_cnt, ms_d;
  logic [EC_W-1:0] edge_cnt, ec_d;
  logic [HC_W-1:0] hold_cnt, hc_d;
  logic [W-1:0]    cfg_d;
  logic            load_d, locked_d, loss_d;

  // Comparator 0 checks against the acquisition reference, 1 against the live period.
  logic [NUM_CMP-1:0][W-1:0] cmp_b;
  logic [NUM_CMP-1:0]        cmp_nz, cmp_hit;
  logic                      meas_nz, hit_ref, hit_cfg;

  assign cmp_b = {div_cfg, meas_ref};

  generate
    for (genvar gi = 0; gi < NUM_CMP; gi++) begin : g_cmp
      cr_tol_cmp #(.W(W), .TOL(TOL)) u_cmp (
        .a       (meas_val),
        .b       (cmp_b[gi]),
        .nonzero (cmp_nz[gi]),
        .match   (cmp_hit[gi])
      );
    end
  endgenerate

  // Both comparators see the same measurement, so their zero flags agree.
  assign meas_nz = &cmp_nz;
  assign hit_ref = cmp_hit[0];
  assign hit_cfg = cmp_hit[1];
  assign state   = st_q;

  // Next-state, counter and output decode; disable overrides every state.
  always_comb begin
    st_d   = st_q;
    ref_d  = meas_ref;
    mc_d   = match_cnt;
    ms_d   = miss_cnt;
    ec_d   = edge_cnt;
    hc_d   = hold_cnt;
    cfg_d  = div_cfg;
    load_d = 1'b0;
    loss_d = 1'b0;
    if (!en) begin
      st_d = ST_IDLE;
    end else begin
      case (st_q)
        ST_IDLE: begin
          st_d   = ST_ACQUIRE;
          cfg_d  = DEF_V;
          load_d = 1'b1;
          mc_d   = '0;
        end
        ST_ACQUIRE: begin
          if (meas_valid) begin
            if (!meas_nz) begin
              mc_d = '0;
            end else if (match_cnt == '0 || !hit_ref) begin
              ref_d = meas_val;
              mc_d  = MC_W'(1);
            end else if (match_cnt >= LOCK_LAST) begin
              st_d   = ST_LOCKED;
              cfg_d  = meas_val;
              load_d = 1'b1;
              mc_d   = '0;
              ms_d   = '0;
              ec_d   = '0;
            end else begin
              mc_d = match_cnt + 1'b1;
            end
          end
        end
        ST_LOCKED: begin
          if (edge_pulse)                ec_d = '0;
          else if (edge_cnt != EDGE_TOP) ec_d = edge_cnt + 1'b1;
          // Edge starvation is checked first so it wins over a good measurement.
          if (!edge_pulse && edge_cnt >= EDGE_LAST) begin
            st_d   = ST_HOLDOVER;
            loss_d = 1'b1;
            hc_d   = '0;
          end else if (meas_valid) begin
            if (hit_cfg) begin
              ms_d   = '0;
              cfg_d  = meas_val;
              load_d = (meas_val != div_cfg);
            end else if (miss_cnt >= MISS_LAST) begin
              st_d   = ST_HOLDOVER;
              loss_d = 1'b1;
              hc_d   = '0;
            end else begin
              ms_d = miss_cnt + 1'b1;
            end
          end
        end
        ST_HOLDOVER: begin
          hc_d = hold_cnt + 1'b1;
          // A good measurement beats expiry on the same cycle.
          if (meas_valid && hit_cfg) begin
            st_d   = ST_LOCKED;
            ms_d   = '0;
            ec_d   = '0;
            cfg_d  = meas_val;
            load_d = (meas_val != div_cfg);
          end else if (hold_cnt >= HOLD_LAST) begin
            st_d   = ST_ACQUIRE;
            cfg_d  = DEF_V;
            load_d = 1'b1;
            mc_d   = '0;
          end
        end
        default: st_d = ST_IDLE;
      endcase
    end
    locked_d = (st_d == ST_LOCKED);
  end

  // State, counters and all outputs are registered; reset wins over any strobe.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      st_q      <= ST_IDLE;
      meas_ref  <= '0;
      match_cnt <= '0;
      miss_cnt  <= '0;
      edge_cnt  <= '0;
      hold_cnt  <= '0;
      div_cfg   <= DEF_V;
      div_load  <= 1'b0;
      locked    <= 1'b0;
      lock_loss <= 1'b0;
    end else begin
      st_q      <= st_d;
      meas_ref  <= ref_d;
      match_cnt <= mc_d;
      miss_cnt  <= ms_d;
      edge_cnt  <= ec_d;
      hold_cnt  <= hc_d;
      div_cfg   <= cfg_d;
      div_load  <= load_d;
      locked    <= locked_d;
      lock_loss <= loss_d;
    end
  end

endmodule

// File: tb/tb_clock_recovery_ctrl.sv
// Directed bench for clock_recovery_ctrl with a div_load scoreboard.
module tb_clock_recovery_ctrl;

  localparam int W       = 24;
  localparam int EDGE_TO = 64;
  localparam int HOLD    = 100;

  logic         sys_clk = 1'b0;
  logic         rst, en, edge_pulse, meas_valid;
  logic [W-1:0] meas_val;
  logic [W-1:0] div_cfg;
  logic         div_load, locked, lock_loss;
  logic [1:0]   state;

  int total = 0;
  int bad   = 0;
  int loss_seen = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_e;

  clock_recovery_ctrl #(
    .W(W), .DEF_CFG(7982), .TOL(64), .LOCK_CNT(3), .MISS_MAX(2),
    .EDGE_TIMEOUT(EDGE_TO), .HOLD_MAX(HOLD)
  ) dut (
    .sys_clk    (sys_clk),
    .rst        (rst),
    .en         (en),
    .edge_pulse (edge_pulse),
    .meas_valid (meas_valid),
    .meas_val   (meas_val),
    .div_cfg    (div_cfg),
    .div_load   (div_load),
    .locked     (locked),
    .state      (state),
    .lock_loss  (lock_loss)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic strobe(input logic [W-1:0] v);
    meas_valid = 1'b1;
    meas_val   = v;
    cyc();
    meas_valid = 1'b0;
    meas_val   = '0;
  endtask

  task automatic pulse_edge();
    edge_pulse = 1'b1;
    cyc();
    edge_pulse = 1'b0;
  endtask

  // Scoreboard: every div_load must match the next expected period, in order.
  always @(negedge sys_clk) begin
    if (lock_loss) loss_seen++;
    if (div_load) begin
      total++;
      assert (exp_q.size() != 0) else begin
        bad++;
        $error("FAIL unexpected_load: got load with div_cfg=%0d expected no load", div_cfg);
      end
      if (exp_q.size() != 0) begin
        exp_e = exp_q.pop_front();
        total++;
        assert (div_cfg === exp_e) else begin
          bad++;
          $error("FAIL load_value: got %0d expected %0d", div_cfg, exp_e);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; en = 1'b0; edge_pulse = 1'b0; meas_valid = 1'b0; meas_val = '0;
    idle(3);
    chk("rst_state",  state,     0);
    chk("rst_cfg",    div_cfg,   7982);
    chk("rst_load",   div_load,  0);
    chk("rst_locked", locked,    0);
    chk("rst_loss",   lock_loss, 0);

    // enable -> ACQUIRE with default period loaded
    rst = 1'b0; en = 1'b1;
    exp_q.push_back(7982); cyc();
    chk("acq_state", state,    1);
    chk("acq_load",  div_load, 1);
    chk("acq_cfg",   div_cfg,  7982);
    cyc();
    chk("acq_load_once", div_load, 0);

    // three matching measurements lock to the last one
    strobe(8000); chk("acq1_state", state, 1);
    strobe(8030); chk("acq2_state", state, 1);
    exp_q.push_back(7990); strobe(7990);
    chk("lock_state",  state,   2);
    chk("lock_locked", locked,  1);
    chk("lock_cfg",    div_cfg, 7990);

    // disable while locked
    en = 1'b0; cyc();
    chk("dis_state",  state,     0);
    chk("dis_locked", locked,    0);
    chk("dis_loss",   lock_loss, 0);
    chk("dis_cfg",    div_cfg,   7990);

    // a mismatch restarts the count from the new value
    en = 1'b1; exp_q.push_back(7982); cyc();
    chk("reacq_state", state, 1);
    strobe(8000); strobe(9000); strobe(9010);
    chk("no_early_lock", state, 1);
    exp_q.push_back(9020); strobe(9020);
    chk("lock2_state", state,   2);
    chk("lock2_cfg",   div_cfg, 9020);

    // relock at 8000 for the LOCKED tests
    en = 1'b0; cyc();
    en = 1'b1; exp_q.push_back(7982); cyc();
    strobe(8000); strobe(8000);
    exp_q.push_back(8000); strobe(8000);
    chk("lock3_cfg", div_cfg, 8000);
    strobe(8000);                          // same value: no load
    exp_q.push_back(8064); strobe(8064);   // diff exactly TOL
    chk("tol_edge_cfg", div_cfg, 8064);
    exp_q.push_back(8000); strobe(8000);
    strobe(8065);                          // diff TOL+1: miss
    chk("miss1_state", state,   2);
    chk("miss1_cfg",   div_cfg, 8000);
    strobe(8000);                          // good: clears miss count
    strobe(9000);
    chk("miss_cleared", state, 2);
    strobe(9000);
    chk("hold_state",  state,     3);
    chk("hold_loss",   lock_loss, 1);
    chk("hold_locked", locked,    0);
    chk("hold_cfg",    div_cfg,   8000);
    cyc();
    chk("loss_once", lock_loss, 0);
    exp_q.push_back(8020); strobe(8020);
    chk("recover_state",  state,   2);
    chk("recover_locked", locked,  1);
    chk("recover_cfg",    div_cfg, 8020);

    // edge starvation; a good measurement on the timeout cycle loses
    pulse_edge();
    idle(EDGE_TO - 1);
    chk("edge_pre", state, 2);
    strobe(8030);
    chk("edge_to_state", state,     3);
    chk("edge_to_loss",  lock_loss, 1);
    chk("edge_to_cfg",   div_cfg,   8020);

    // holdover expiry falls back to ACQUIRE
    idle(HOLD - 1);
    chk("hold_pre", state, 3);
    exp_q.push_back(7982); cyc();
    chk("expire_state", state,    1);
    chk("expire_cfg",   div_cfg,  7982);
    chk("expire_load",  div_load, 1);

    // good measurement on the expiry cycle returns to LOCKED instead
    strobe(8000); strobe(8000);
    exp_q.push_back(8000); strobe(8000);
    strobe(9000); strobe(9000);
    chk("hold2_state", state, 3);
    idle(HOLD - 1);
    exp_q.push_back(8010); strobe(8010);
    chk("expire_good_state",  state,   2);
    chk("expire_good_locked", locked,  1);
    chk("expire_good_cfg",    div_cfg, 8010);

    // reset mid-ACQUIRE with a strobe present
    en = 1'b0; cyc();
    en = 1'b1; exp_q.push_back(7982); cyc();
    strobe(8000); strobe(8000);
    rst = 1'b1; meas_valid = 1'b1; meas_val = 8000; cyc();
    meas_valid = 1'b0; meas_val = '0;
    chk("mrst_state",  state,     0);
    chk("mrst_locked", locked,    0);
    chk("mrst_loss",   lock_loss, 0);
    chk("mrst_cfg",    div_cfg,   7982);
    rst = 1'b0; exp_q.push_back(7982); cyc();
    chk("post_rst_state", state, 1);
    strobe(8000); strobe(8000);
    chk("fresh_two", state, 1);
    strobe(0); strobe(8000); strobe(8000);
    chk("zero_restart", state, 1);
    exp_q.push_back(8000); strobe(8000);
    chk("final_lock", state, 2);

    cyc();
    chk("loss_count", loss_seen,     3);
    chk("sb_empty",   exp_q.size(),  0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
